// File: rtl/cla_multiword_sequencer.sv
// rtl/cla_multiword_sequencer.sv - WIDTH-bit adder built from one 4-bit carry-lookahead slice reused LSB-first.
module cla_multiword_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [NSLICE-1:0][3:0] a_reg, b_reg, sum_reg;
  logic [IDXW-1:0]        idx;
  logic                   carry;
  logic                   cout_reg;

  logic                   accept;
  logic                   last_slice;

  logic [3:0] s_a, s_b, s_g, s_p, s_sum;
  logic [4:0] s_c;

  // 4-bit lookahead slice: every carry is a flat sum of products of g/p and carry-in.
  always_comb begin
    s_a    = a_reg[idx];
    s_b    = b_reg[idx];
    s_g    = s_a & s_b;
    s_p    = s_a ^ s_b;
    s_c[0] = carry;
    s_c[1] = s_g[0] | (s_p[0] & carry);
    s_c[2] = s_g[1] | (s_p[1] & s_g[0]) | (s_p[1] & s_p[0] & carry);
    s_c[3] = s_g[2] | (s_p[2] & s_g[1]) | (s_p[2] & s_p[1] & s_g[0])
           | (s_p[2] & s_p[1] & s_p[0] & carry);
    s_c[4] = s_g[3] | (s_p[3] & s_g[2]) | (s_p[3] & s_p[2] & s_g[1])
           | (s_p[3] & s_p[2] & s_p[1] & s_g[0])
           | (s_p[3] & s_p[2] & s_p[1] & s_p[0] & carry);
    s_sum  = s_p ^ s_c[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    last_slice = (idx == LAST_IDX);
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) begin
          next_state = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_slice) begin
          next_state = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
    end else if (accept) begin
      a_reg <= in_a;
      b_reg <= in_b;
      carry <= in_cin;
      idx   <= '0;
    end else if (state == RUN) begin
      sum_reg[idx] <= s_sum;
      carry        <= s_c[4];
      if (last_slice) begin
        cout_reg <= s_c[4];
        idx      <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign out_sum  = sum_reg;
  assign out_cout = cout_reg;

endmodule

// File: tb/tb_cla_multiword_sequencer.sv
// tb/tb_cla_multiword_sequencer.sv - randomized self-checking bench against an arithmetic sum model.
module tb_cla_multiword_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a, in_b;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  cla_multiword_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {16'd0, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_add(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input int hold, input logic poke, input string tag);
    logic [16:0] exp;
    int n;
    exp = ref_sum(a, b, c);
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
    check_eq({tag, "_busy_run"}, 32'(busy), 32'd1);
    check_eq({tag, "_rdy_run"}, 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check_eq({tag, "_latency"}, 32'(n), 32'd4);
    check_eq({tag, "_result"}, 32'({out_cout, out_sum}), 32'(exp));
    if (poke) begin
      in_valid = 1'b1; in_a = 16'hAAAA; in_b = 16'hAAAA;
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      check_eq({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, "_hold_result"}, 32'({out_cout, out_sum}), 32'(exp));
      check_eq({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_persist"}, 32'({out_cout, out_sum}), 32'(exp));
    in_valid = 1'b0;
  endtask

  initial begin
    logic [16:0] q_exp[$];
    logic [16:0] e;
    int results, cyc, last_acc;
    logic acc, hs;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0;
    tick(); tick();
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_result", 32'({out_cout, out_sum}), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    do_add(16'h0000, 16'h0000, 1'b0, 0, 1'b0, "zero");
    do_add(16'h00FF, 16'h0001, 1'b0, 0, 1'b0, "ripple");
    do_add(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0, "allones");
    do_add(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0, "wrap");
    do_add(16'h1234, 16'h4321, 1'b1, 5, 1'b1, "stall");

    // Reset mid-add drops the transaction.
    in_a = 16'h7777; in_b = 16'h1111; in_cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_valid", 32'(out_valid), 32'd0);
    check_eq("abort_rdy", 32'(in_ready), 32'd1);
    check_eq("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("abort_quiet", 32'(out_valid), 32'd0);
    end
    do_add(16'h0F0F, 16'h0101, 1'b0, 0, 1'b0, "post_abort");

    for (int i = 0; i < 20; i++)
      do_add(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom), "rand");

    // Back-to-back streaming with both handshakes held high.
    in_valid = 1'b1; out_ready = 1'b1;
    in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
    results = 0; cyc = 0; last_acc = -1;
    while (results < 1000 && cyc < 20000) begin
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (hs) begin
        if (q_exp.size() == 0) begin
          check_eq("stream_spurious", 32'd1, 32'd0);
        end else begin
          e = q_exp.pop_front();
          check_eq("stream_result", 32'({out_cout, out_sum}), 32'(e));
        end
        results++;
      end
      if (acc) begin
        q_exp.push_back(ref_sum(in_a, in_b, in_cin));
        if (last_acc >= 0) check_eq("stream_spacing", 32'(cyc - last_acc), 32'd6);
        last_acc = cyc;
      end
      tick();
      cyc++;
      if (acc) begin
        in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
      end
    end
    check_eq("stream_count", 32'(results), 32'd1000);
    in_valid = 1'b0; out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
